// File: rtl/control_sequencer.sv
// control_sequencer: ring-counter control unit for the 8-bit single-bus CPU.
// A one-hot ring of T-states (T1..T6) plus an absorbing HALT state steps each
// instruction through fetch and execute. Every datapath strobe is a
// combinational decode of (state, opcode) gated by the advance enable, so the
// datapath samples the strobes on the same rising edge that moves the ring.
// This block is the only bus master selector: at most one *_OE is high per cycle.

module control_sequencer #(
  parameter int OPW       = 4,
  parameter bit SKIP_IDLE = 1'b1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           RUN,
  input  logic           STEP,
  input  logic [OPW-1:0] OPCODE,
  output logic           PC_OE,
  output logic           PC_INC,
  output logic           MAR_WE,
  output logic           MEM_OE,
  output logic           IR_WE,
  output logic           IR_OE,
  output logic           ACC_WE,
  output logic           ACC_OE,
  output logic           B_WE,
  output logic           ALU_OE,
  output logic           ALU_SUB,
  output logic           OUT_WE,
  output logic [2:0]     T_STATE,
  output logic           HALTED,
  output logic           INSTR_DONE
);

  // One-hot ring encoding; bit 6 is the absorbing HALT state.
  localparam logic [6:0] ST_T1   = 7'b000_0001;
  localparam logic [6:0] ST_T2   = 7'b000_0010;
  localparam logic [6:0] ST_T3   = 7'b000_0100;
  localparam logic [6:0] ST_T4   = 7'b000_1000;
  localparam logic [6:0] ST_T5   = 7'b001_0000;
  localparam logic [6:0] ST_T6   = 7'b010_0000;
  localparam logic [6:0] ST_HALT = 7'b100_0000;

  // Opcodes carried in the IR upper nibble.
  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  // Bit positions inside the internal strobe vector.
  localparam int SB_PC_OE   = 11;
  localparam int SB_PC_INC  = 10;
  localparam int SB_MAR_WE  = 9;
  localparam int SB_MEM_OE  = 8;
  localparam int SB_IR_WE   = 7;
  localparam int SB_IR_OE   = 6;
  localparam int SB_ACC_WE  = 5;
  localparam int SB_ACC_OE  = 4;
  localparam int SB_B_WE    = 3;
  localparam int SB_ALU_OE  = 2;
  localparam int SB_ALU_SUB = 1;
  localparam int SB_OUT_WE  = 0;

  logic [6:0]  state_r;
  logic [6:0]  state_nxt_s;
  logic        adv_s;
  logic        op_lda_s;
  logic        op_add_s;
  logic        op_sub_s;
  logic        op_out_s;
  logic        op_hlt_s;
  logic        op_nop_s;
  logic        last_s;
  logic        done_s;
  logic [11:0] strobe_s;
  logic [11:0] strobe_safe_s;

  // Debug T-state number of a ring state; HALT (and anything illegal) reads 0.
  function automatic logic [2:0] state_num(input logic [6:0] st);
    logic [2:0] num;
    case (st)
      ST_T1:   num = 3'd1;
      ST_T2:   num = 3'd2;
      ST_T3:   num = 3'd3;
      ST_T4:   num = 3'd4;
      ST_T5:   num = 3'd5;
      ST_T6:   num = 3'd6;
      default: num = 3'd0;
    endcase
    return num;
  endfunction

  // Last line of defence for bus ownership: keep only the highest-priority
  // output enable and never let PC_INC coincide with PC_OE.
  function automatic logic [11:0] bus_guard(input logic [11:0] s);
    logic [11:0] g;
    g = s;
    if (g[SB_PC_OE]) begin
      g[SB_MEM_OE] = 1'b0;
      g[SB_IR_OE]  = 1'b0;
      g[SB_ACC_OE] = 1'b0;
      g[SB_ALU_OE] = 1'b0;
      g[SB_PC_INC] = 1'b0;
    end else if (g[SB_MEM_OE]) begin
      g[SB_IR_OE]  = 1'b0;
      g[SB_ACC_OE] = 1'b0;
      g[SB_ALU_OE] = 1'b0;
    end else if (g[SB_IR_OE]) begin
      g[SB_ACC_OE] = 1'b0;
      g[SB_ALU_OE] = 1'b0;
    end else if (g[SB_ACC_OE]) begin
      g[SB_ALU_OE] = 1'b0;
    end else begin
      g = s;
    end
    return g;
  endfunction

  // RUN free-runs, STEP advances once while stalled; both together is one step.
  assign adv_s = RUN | STEP;

  // Opcode class decode; anything unlisted behaves as a NOP.
  always_comb begin
    op_lda_s = (OPCODE == OP_LDA);
    op_add_s = (OPCODE == OP_ADD);
    op_sub_s = (OPCODE == OP_SUB);
    op_out_s = (OPCODE == OP_OUT);
    op_hlt_s = (OPCODE == OP_HLT);
    op_nop_s = ~(op_lda_s | op_add_s | op_sub_s | op_out_s | op_hlt_s);
  end

  // Final T-state of the current instruction: short instructions retire early
  // when idle states are skipped, otherwise every instruction ends in T6.
  always_comb begin
    last_s = (state_r == ST_T6);
    if (SKIP_IDLE) begin
      if ((state_r == ST_T4) && (op_out_s || op_nop_s)) begin
        last_s = 1'b1;
      end else if ((state_r == ST_T5) && op_lda_s) begin
        last_s = 1'b1;
      end else begin
        last_s = (state_r == ST_T6);
      end
    end else begin
      last_s = (state_r == ST_T6);
    end
  end

  // State register: asynchronous reset restarts the ring at T1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_T1;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: hold while stalled, HALT is absorbing, illegal codes recover to T1.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_T1: begin
        if (adv_s) state_nxt_s = ST_T2;
        else       state_nxt_s = ST_T1;
      end
      ST_T2: begin
        if (adv_s) state_nxt_s = ST_T3;
        else       state_nxt_s = ST_T2;
      end
      ST_T3: begin
        if (adv_s) state_nxt_s = ST_T4;
        else       state_nxt_s = ST_T3;
      end
      ST_T4: begin
        if (!adv_s)        state_nxt_s = ST_T4;
        else if (op_hlt_s) state_nxt_s = ST_HALT;
        else if (last_s)   state_nxt_s = ST_T1;
        else               state_nxt_s = ST_T5;
      end
      ST_T5: begin
        if (!adv_s)      state_nxt_s = ST_T5;
        else if (last_s) state_nxt_s = ST_T1;
        else             state_nxt_s = ST_T6;
      end
      ST_T6: begin
        if (adv_s) state_nxt_s = ST_T1;
        else       state_nxt_s = ST_T6;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_T1;
    endcase
  end

  // Output decode: strobes for the current T-state, silenced during reset or stall.
  always_comb begin
    strobe_s = 12'd0;
    done_s   = 1'b0;
    if (!RESET && adv_s) begin
      case (state_r)
        ST_T1: begin
          strobe_s[SB_PC_OE]  = 1'b1;
          strobe_s[SB_MAR_WE] = 1'b1;
        end
        ST_T2: begin
          strobe_s[SB_PC_INC] = 1'b1;
        end
        ST_T3: begin
          strobe_s[SB_MEM_OE] = 1'b1;
          strobe_s[SB_IR_WE]  = 1'b1;
        end
        ST_T4: begin
          if (op_lda_s || op_add_s || op_sub_s) begin
            strobe_s[SB_IR_OE]  = 1'b1;
            strobe_s[SB_MAR_WE] = 1'b1;
          end else if (op_out_s) begin
            strobe_s[SB_ACC_OE] = 1'b1;
            strobe_s[SB_OUT_WE] = 1'b1;
          end else begin
            strobe_s = 12'd0;
          end
        end
        ST_T5: begin
          if (op_lda_s) begin
            strobe_s[SB_MEM_OE] = 1'b1;
            strobe_s[SB_ACC_WE] = 1'b1;
          end else if (op_add_s || op_sub_s) begin
            strobe_s[SB_MEM_OE]  = 1'b1;
            strobe_s[SB_B_WE]    = 1'b1;
            strobe_s[SB_ALU_SUB] = op_sub_s;
          end else begin
            strobe_s = 12'd0;
          end
        end
        ST_T6: begin
          if (op_add_s || op_sub_s) begin
            strobe_s[SB_ALU_OE]  = 1'b1;
            strobe_s[SB_ACC_WE]  = 1'b1;
            strobe_s[SB_ALU_SUB] = op_sub_s;
          end else begin
            strobe_s = 12'd0;
          end
        end
        ST_HALT: strobe_s = 12'd0;
        default: strobe_s = 12'd0;
      endcase
      done_s = last_s;
    end else begin
      strobe_s = 12'd0;
      done_s   = 1'b0;
    end
  end

  assign strobe_safe_s = bus_guard(strobe_s);

  assign PC_OE      = strobe_safe_s[SB_PC_OE];
  assign PC_INC     = strobe_safe_s[SB_PC_INC];
  assign MAR_WE     = strobe_safe_s[SB_MAR_WE];
  assign MEM_OE     = strobe_safe_s[SB_MEM_OE];
  assign IR_WE      = strobe_safe_s[SB_IR_WE];
  assign IR_OE      = strobe_safe_s[SB_IR_OE];
  assign ACC_WE     = strobe_safe_s[SB_ACC_WE];
  assign ACC_OE     = strobe_safe_s[SB_ACC_OE];
  assign B_WE       = strobe_safe_s[SB_B_WE];
  assign ALU_OE     = strobe_safe_s[SB_ALU_OE];
  assign ALU_SUB    = strobe_safe_s[SB_ALU_SUB];
  assign OUT_WE     = strobe_safe_s[SB_OUT_WE];
  assign INSTR_DONE = done_s;
  assign T_STATE    = state_num(state_r);
  assign HALTED     = (state_r == ST_HALT);

endmodule
